// File: rtl/tx_channel.sv
// Router output-port transmitter: buffers granted flits and drives them over a 4-phase req/ack link.
// busy = FIFO full. First req appears one cycle after a push into an empty FIFO.
module tx_channel #(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 10,
  parameter bit SYNC_ACK = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] item_in,
  input  logic              ena,
  output logic              busy,
  output logic [DATA_W-1:0] link_data,
  output logic              link_req,
  input  logic              link_ack,
  output logic [15:0]       tx_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q, count_d;
  state_t            state_q;
  logic              link_req_q;
  logic [DATA_W-1:0] link_data_q;
  logic [15:0]       tx_count_q;
  logic              ack_s;
  logic              push, pop;

  generate
    if (SYNC_ACK) begin : g_sync
      logic [1:0] sync_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[0], link_ack};
      end
      assign ack_s = sync_q[1];
    end else begin : g_nosync
      assign ack_s = link_ack;
    end
  endgenerate

  assign busy    = (count_q == CW'(DEPTH));
  assign push    = ena && !busy;
  // Pop coincides with the ack-accept edge, so the flit stays in the FIFO for the whole REQ phase.
  assign pop     = (state_q == REQ) && ack_s;
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= item_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + AW'(1);
      if (pop)  head_q <= head_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      link_req_q  <= 1'b0;
      link_data_q <= '0;
      tx_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            link_data_q <= mem_q[head_q];
            link_req_q  <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            link_req_q <= 1'b0;
            tx_count_q <= tx_count_q + 16'd1;
            state_q    <= REL;
          end
        end
        REL: begin
          if (!ack_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign link_req  = link_req_q;
  assign link_data = link_data_q;
  assign tx_count  = tx_count_q;

  always @(posedge clk) begin
    assert (!(reset && ena && busy))
      else $error("tx_channel: ena asserted while busy, flit dropped");
  end
endmodule
